sum_accum: RTL
==============

# sum_accum

Burst accumulator directly downstream of the 4-bit adder `add4`. It consumes the adder's `{cout, s}` result stream over a valid/ready handshake and sums a fixed-length burst of results into a wider running total. It also counts carry-outs and presents the totals on an output handshake. It is the first sequential consumer of adder results in the datapath.

## Interface
- `SUM_W`, 4, width of the adder sum input.
- `ACC_W`, 8, width of the accumulated total.
- `BURST_LEN`, 10, number of samples per burst (≥1).
- `CNT_W`, `$clog2(BURST_LEN+1)`, width of the sample and carry counters (derived localparam).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a burst; sampled only in IDLE.
- `in_valid`  in  1  adder result present.
- `in_ready`  out  1  block accepts a result.
- `in_sum`  in  SUM_W  adder sum `s`.
- `in_cout`  in  1  adder carry-out.
- `out_valid`  out  1  burst result available.
- `out_ready`  in  1  downstream takes the result.
- `out_total`  out  ACC_W  accumulated total.
- `out_carries`  out  CNT_W  number of samples with `in_cout`=1.
- `out_ovf`  out  1  sticky flag: total exceeded 2^ACC_W−1 during the burst.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Sample value: zero-extended `{in_cout, in_sum}`, range 0..2^(SUM_W+1)−1.
- Accept condition: `in_valid && in_ready`.
- State IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 clears the total, carry count, sample count and `out_ovf`, then moves to ACCUM.
- State ACCUM:
  - `in_ready`=1.
  - On each accept: total += sample; carry count += `in_cout`; sample count += 1.
  - The accept that brings the sample count to `BURST_LEN` moves the state to DONE.
  - `start` is ignored.
- State DONE:
  - `out_valid`=1, `in_ready`=0.
  - Outputs are held stable until `out_valid && out_ready`, which moves the state to IDLE.
  - `start` is ignored, including in the handshake cycle.
- Arithmetic: the add is performed at ACC_W+1 bits. If bit ACC_W is set, `out_ovf` is set and stays set until the next `start`. Default behaviour wraps the total mod 2^ACC_W.
- `out_total`, `out_carries` and `out_ovf` are registered and always show the current accumulator contents, including outside DONE.
- `in_valid` gaps (bubbles) stall accumulation without side effects.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; `in_ready`=0, `out_valid`=0, `out_total`=0, `out_carries`=0, `out_ovf`=0, `busy`=0.
- `start` seen at edge N → ACCUM, with `in_ready`=1 from cycle N+1.
- Last accept at edge M → `out_valid`=1 in cycle M+1.
- Minimum burst latency: BURST_LEN+1 cycles from the first accept to `out_valid`.
- `out_valid && out_ready` at edge K → IDLE in cycle K+1. The earliest next `start` is sampled at edge K+1.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from inputs to them.
- Reset asserted mid-burst: all state clears immediately and any partial burst is discarded.

## Configuration
- `SUM_ACCUM_SAT_EN` defined: on overflow the total clamps to 2^ACC_W−1 and stays there for the rest of the burst. `out_ovf` behaves as in the default mode.
- Not defined: the total wraps mod 2^ACC_W, as described under Operation.

## Test plan
- Defaults, 10 samples with `in_sum`=3, `in_cout`=0 → `out_total`=30, `out_carries`=0, `out_ovf`=0; `out_valid` asserted in the cycle after the 10th accept.
- 10 samples with `in_sum`=4'hF, `in_cout`=1 (value 31 each) → `out_carries`=10, `out_ovf`=1. `out_total`=0x36 by default; 0xFF with `SUM_ACCUM_SAT_EN`.
- `in_valid` toggled every other cycle, 10 samples of value 5 → `out_total`=50, with `out_valid` asserted the cycle after the 10th accept.
- `out_ready` held low 5 cycles in DONE, with `start` and `in_valid` pulsed → outputs stable, `in_ready`=0, no new burst. After `out_ready`=1 → IDLE the next cycle.
- `rst_n` pulsed low after 4 accepts → all outputs 0 immediately. The next burst of 10 samples of value 1 gives `out_total`=10.
- Random `{cout, s}` stream compared against a reference model over 100 bursts with random `out_ready` → exact match on total, carries and ovf.

Source files
------------

// File: rtl/sum_accum.sv
// ---------------------------------------------------------------------------
// sum_accum
//
// Burst accumulator sitting directly behind the 4-bit adder. It takes the
// adder's {cout, s} results over a valid/ready handshake, adds BURST_LEN of
// them into a wider running total, counts how many carried out, and then
// offers the totals on an output valid/ready handshake.
//
// Optional feature macro: SUM_ACCUM_SAT_EN
//    defined     -> on overflow the total clamps to 2^ACC_W-1 for the rest
//                   of the burst
//    not defined -> the total wraps mod 2^ACC_W
//    out_ovf is a sticky overflow flag in both modes.
//
// Ports
//    clk          in   rising-edge clock
//    rst_n        in   asynchronous active-low reset
//    start        in   begins a burst (sampled only while idle)
//    in_valid     in   adder result present
//    in_ready     out  block accepts a result (accumulating)
//    in_sum       in   adder sum s [SUM_W]
//    in_cout      in   adder carry-out
//    out_valid    out  burst result available
//    out_ready    in   downstream takes the result
//    out_total    out  accumulated total [ACC_W]
//    out_carries  out  number of accepted samples with carry-out [CNT_W]
//    out_ovf      out  sticky overflow flag for the current burst
//    busy         out  not idle
// ---------------------------------------------------------------------------
module sum_accum #(
   parameter  int SUM_W     = 4,
   parameter  int ACC_W     = 8,
   parameter  int BURST_LEN = 10,
   localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] in_sum,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic [CNT_W-1:0] out_carries,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_nextState;

   logic [ACC_W-1:0]   r_total;
   logic [CNT_W-1:0]   r_carries;
   logic [CNT_W-1:0]   r_count;
   logic               r_ovf;

   logic               w_accept;
   logic               w_lastSample;
   logic [ACC_W:0]     w_sample;
   logic [ACC_W:0]     w_sum;
   logic [ACC_W-1:0]   w_nextTotal;

   // Handshake outputs come straight from the registered state so that no
   // input can reach them combinationally.
   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);

   assign out_total   = r_total;
   assign out_carries = r_carries;
   assign out_ovf     = r_ovf;

   assign w_accept     = in_valid && (r_state == ACCUM);
   assign w_lastSample = (r_count == CNT_W'(BURST_LEN - 1));

   // The add is done one bit wider than the total so the carry out of the
   // accumulator is visible as the overflow indication.
   always_comb begin
      w_sample    = (ACC_W + 1)'({in_cout, in_sum});
      w_sum       = {1'b0, r_total} + w_sample;
`ifdef SUM_ACCUM_SAT_EN
      // Once clamped, any further non-zero add overflows again, so the
      // total naturally stays pinned at full scale for the rest of the burst.
      w_nextTotal = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
      w_nextTotal = w_sum[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // start only matters while idle; in ACCUM and DONE it is ignored.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = ACCUM;
            end
         end
         ACCUM: begin
            if (w_accept && w_lastSample) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Accumulator contents persist after the output handshake and are only
   // cleared by the next start (or reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_total   <= '0;
         r_carries <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
      end else if ((r_state == IDLE) && start) begin
         r_total   <= '0;
         r_carries <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
      end else if (w_accept) begin
         r_total   <= w_nextTotal;
         r_carries <= r_carries + CNT_W'(in_cout);
         r_count   <= r_count + CNT_W'(1);
         r_ovf     <= r_ovf | w_sum[ACC_W];
      end
   end

endmodule
